avmm_onchip_ram_2p: RTL and testbench



---
 rtl/avmm_ram_pkg.sv | 19 +
 rtl/avmm_onchip_ram_2p_if.sv | 30 +++
 rtl/avmm_ram_read_pipe.sv | 42 ++++
 rtl/avmm_onchip_ram_2p.sv | 143 ++++++++++++++
 tb/tb_avmm_onchip_ram_2p.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_ram_pkg.sv
// Shared types and helpers for the dual-port Avalon-MM on-chip RAM.
package avmm_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

    // Number of byte lanes for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Only a bare array read (1) or one extra output register (2) is built.
    function automatic bit read_latency_ok(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

endpackage

// File: rtl/avmm_onchip_ram_2p_if.sv
// One Avalon-MM slave port of the on-chip RAM.
interface avmm_onchip_ram_2p_if
    import avmm_ram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int BE_W = be_width(DATA_W);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/avmm_ram_read_pipe.sv
// Read-return pipeline for one port: LATENCY stages of valid/data.
// Data stages only load when their valid input is set, so readdata holds
// the last returned word between reads.
module avmm_ram_read_pipe
    import avmm_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] vld;
    logic [DATA_W-1:0]  dat [LATENCY];

    // Shift valid/data forward on every enabled cycle; flush on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
        end else if (clken) begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    // A held valid is masked while frozen so it is seen exactly once by an
    // enable-qualified master.
    assign out_valid = vld[LATENCY-1] & clken;
    assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/avmm_onchip_ram_2p.sv
// Dual-port Avalon-MM on-chip RAM with post-reset clear sweep, same-address
// write collision stall on s2, and sticky out-of-range flag.
module avmm_onchip_ram_2p
    import avmm_ram_pkg::*;
#(
    parameter int              DATA_W         = 32,
    parameter int              ADDR_W         = 16,
    parameter int              DEPTH          = 51200,
    parameter int              READ_LATENCY   = 1,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    avmm_onchip_ram_2p_if.slave s1,
    avmm_onchip_ram_2p_if.slave s2,
    output logic init_busy,
    output logic oor_error
);

    localparam int                BE_W       = be_width(DATA_W);
    localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   SWEEP_LAST = (ADDR_W+1)'(DEPTH - 1);

    if (!read_latency_ok(READ_LATENCY) || (DATA_W % 8 != 0) || (DEPTH > 2**ADDR_W)) begin : g_bad_cfg
        $error("avmm_onchip_ram_2p: illegal READ_LATENCY, DATA_W or DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    ram_state_e      state, state_nxt;
    logic [ADDR_W:0] sweep, sweep_nxt;
    logic            clr_we;

    logic              wait1, wait2, collide;
    logic              wr_acc1, wr_acc2, rd_acc1, rd_acc2, acc1, acc2;
    logic              in1, in2;
    logic [IDX_W-1:0]  idx1, idx2, sweep_idx;
    logic [DATA_W-1:0] rdata1, rdata2;

    // State and sweep counter; reset restarts the sweep from address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            sweep <= '0;
        end else if (clken) begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // Sweep writes one word per enabled cycle and hands over after DEPTH-1.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (sweep == SWEEP_LAST) begin
                    state_nxt = RUN;
                    sweep_nxt = '0;
                end else begin
                    sweep_nxt = sweep + 1'b1;
                end
            end
            RUN: begin
            end
            default: state_nxt = RUN;
        endcase
    end

    // Handshake, acceptance, range and collision decode for both ports.
    always_comb begin
        init_busy = (state == CLEAR);
        wait1     = ~reset_n | init_busy | ~clken;
        wr_acc1   = s1.chipselect & s1.write & ~wait1;
        collide   = wr_acc1 & s2.chipselect & s2.write & (s1.address == s2.address);
        wait2     = wait1 | collide;
        wr_acc2   = s2.chipselect & s2.write & ~wait2;
        rd_acc1   = s1.chipselect & s1.read & ~s1.write & ~wait1;
        rd_acc2   = s2.chipselect & s2.read & ~s2.write & ~wait2;
        acc1      = s1.chipselect & (s1.read | s1.write) & ~wait1;
        acc2      = s2.chipselect & (s2.read | s2.write) & ~wait2;
        in1       = {1'b0, s1.address} < DEPTH_W;
        in2       = {1'b0, s2.address} < DEPTH_W;
        idx1      = s1.address[IDX_W-1:0];
        idx2      = s2.address[IDX_W-1:0];
        sweep_idx = sweep[IDX_W-1:0];
        rdata1    = in1 ? mem[idx1] : '0;
        rdata2    = in2 ? mem[idx2] : '0;
    end

    assign s1.waitrequest = wait1;
    assign s2.waitrequest = wait2;

    // Array writes; both ports can write in one cycle since collisions on
    // the same word have already stalled s2. Reads sample before the update.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (clr_we) mem[sweep_idx] <= CLEAR_VALUE;
            if (wr_acc1 && in1) begin
                for (int b = 0; b < BE_W; b++)
                    if (s1.byteenable[b]) mem[idx1][b*8 +: 8] <= s1.writedata[b*8 +: 8];
            end
            if (wr_acc2 && in2) begin
                for (int b = 0; b < BE_W; b++)
                    if (s2.byteenable[b]) mem[idx2][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            end
        end
    end

    // Sticky flag for any accepted access beyond the implemented depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            oor_error <= 1'b0;
        else if (clken && ((acc1 && !in1) || (acc2 && !in2)))
            oor_error <= 1'b1;
    end

    avmm_ram_read_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .in_valid  (rd_acc1),
        .in_data   (rdata1),
        .out_valid (s1.readdatavalid),
        .out_data  (s1.readdata)
    );

    avmm_ram_read_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .in_valid  (rd_acc2),
        .in_data   (rdata2),
        .out_valid (s2.readdatavalid),
        .out_data  (s2.readdata)
    );

endmodule

// File: tb/tb_avmm_onchip_ram_2p.sv
// Bench for avmm_onchip_ram_2p: two instances (read latency 1 and 2) share
// the same stimulus; read results are checked by a per-port scoreboard.
module tb_avmm_onchip_ram_2p;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ex;
    } req_t;

    typedef struct {
        bit   port;
        req_t r;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk, reset_n, clken;
    logic busy_a, busy_b, oor_a, oor_b;
    req_t r1, r2;

    int total = 0;
    int bad   = 0;
    int ccnt  = 0;
    int lat [4] = '{1, 1, 2, 2};
    string pn [4] = '{"a_s1", "a_s2", "b_s1", "b_s2"};
    exp_t sbq [4][$];

    logic        vld [4];
    logic        wt  [4];
    logic [31:0] rdt [4];

    avmm_onchip_ram_2p_if #(.ADDR_W(5), .DATA_W(32)) a1 ();
    avmm_onchip_ram_2p_if #(.ADDR_W(5), .DATA_W(32)) a2 ();
    avmm_onchip_ram_2p_if #(.ADDR_W(5), .DATA_W(32)) b1 ();
    avmm_onchip_ram_2p_if #(.ADDR_W(5), .DATA_W(32)) b2 ();

    avmm_onchip_ram_2p #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(1),
                         .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) ua (
        .clk(clk), .reset_n(reset_n), .clken(clken), .s1(a1), .s2(a2),
        .init_busy(busy_a), .oor_error(oor_a));

    avmm_onchip_ram_2p #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(2),
                         .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) ub (
        .clk(clk), .reset_n(reset_n), .clken(clken), .s1(b1), .s2(b2),
        .init_busy(busy_b), .oor_error(oor_b));

    always_comb begin
        a1.address = r1.addr; a1.chipselect = r1.rd | r1.wr; a1.read = r1.rd; a1.write = r1.wr;
        a1.byteenable = r1.be; a1.writedata = r1.wd;
        b1.address = r1.addr; b1.chipselect = r1.rd | r1.wr; b1.read = r1.rd; b1.write = r1.wr;
        b1.byteenable = r1.be; b1.writedata = r1.wd;
        a2.address = r2.addr; a2.chipselect = r2.rd | r2.wr; a2.read = r2.rd; a2.write = r2.wr;
        a2.byteenable = r2.be; a2.writedata = r2.wd;
        b2.address = r2.addr; b2.chipselect = r2.rd | r2.wr; b2.read = r2.rd; b2.write = r2.wr;
        b2.byteenable = r2.be; b2.writedata = r2.wd;
        vld[0] = a1.readdatavalid; vld[1] = a2.readdatavalid;
        vld[2] = b1.readdatavalid; vld[3] = b2.readdatavalid;
        wt[0] = a1.waitrequest; wt[1] = a2.waitrequest;
        wt[2] = b1.waitrequest; wt[3] = b2.waitrequest;
        rdt[0] = a1.readdata; rdt[1] = a2.readdata;
        rdt[2] = b1.readdata; rdt[3] = b2.readdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (reset_n && clken) ccnt <= ccnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic req_t rq(input bit rd, input bit wr, input int addr,
                                input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ex);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr[4:0]; r.be = be; r.wd = wd; r.ex = ex;
        return r;
    endfunction

    function automatic req_t nop();
        return rq(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endfunction

    // Read-return scoreboard: data and arrival cycle per port and instance.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k]) begin
                    if (!clken) begin
                        chk({pn[k], "_valid_frozen"}, {31'b0, vld[k]}, 32'd0);
                    end else if (sbq[k].size() == 0) begin
                        chk({pn[k], "_valid_unexpected"}, {31'b0, vld[k]}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq[k].pop_front();
                        chk({pn[k], "_rdata"}, rdt[k], e.data);
                        chk({pn[k], "_rd_latency"}, ccnt, e.due);
                    end
                end else if (clken && sbq[k].size() != 0 && sbq[k][0].due <= ccnt) begin
                    chk({pn[k], "_valid_missing"}, {31'b0, vld[k]}, 32'd1);
                    void'(sbq[k].pop_front());
                end
            end
        end
    end

    task automatic do_cycle(input req_t q1, input req_t q2, input logic ce,
                            input logic ew1, input logic ew2);
        @(posedge clk); #1;
        r1 = q1; r2 = q2; clken = ce;
        @(negedge clk);
        chk("a_s1_wait", {31'b0, wt[0]}, {31'b0, ew1});
        chk("a_s2_wait", {31'b0, wt[1]}, {31'b0, ew2});
        chk("b_s1_wait", {31'b0, wt[2]}, {31'b0, ew1});
        chk("b_s2_wait", {31'b0, wt[3]}, {31'b0, ew2});
        if (q1.rd && !q1.wr && !ew1) begin
            sbq[0].push_back('{q1.ex, ccnt + lat[0]});
            sbq[2].push_back('{q1.ex, ccnt + lat[2]});
        end
        if (q2.rd && !q2.wr && !ew2) begin
            sbq[1].push_back('{q2.ex, ccnt + lat[1]});
            sbq[3].push_back('{q2.ex, ccnt + lat[3]});
        end
    endtask

    task automatic drain();
        repeat (4) do_cycle(nop(), nop(), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) chk({pn[k], "_queue_left"}, sbq[k].size(), 32'd0);
    endtask

    task automatic check_reset_values();
        chk("a_init_busy_rst", {31'b0, busy_a}, 32'd1);
        chk("b_init_busy_rst", {31'b0, busy_b}, 32'd1);
        chk("a_oor_rst", {31'b0, oor_a}, 32'd0);
        chk("b_oor_rst", {31'b0, oor_b}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk({pn[k], "_wait_rst"}, {31'b0, wt[k]}, 32'd1);
            chk({pn[k], "_valid_rst"}, {31'b0, vld[k]}, 32'd0);
            chk({pn[k], "_rdata_rst"}, rdt[k], 32'd0);
        end
    endtask

    // Counts cycles of init_busy starting in the cycle reset was released.
    task automatic count_sweep(output int n);
        int stall_bad = 0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            if (busy_b !== busy_a || !(wt[0] & wt[1] & wt[2] & wt[3])) stall_bad++;
            n++;
        end
        chk("sweep_stall", stall_bad, 32'd0);
        chk("b_busy_after_sweep", {31'b0, busy_b}, 32'd0);
    endtask

    vec_t tbl[$];
    int   n;

    initial begin
        r1 = nop(); r2 = nop(); clken = 1'b1; reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_reset_values();
        reset_n = 1'b1;
        count_sweep(n);
        chk("sweep_len", n, 32'd16);

        for (int a = 0; a < 16; a++) tbl.push_back('{a[0], rq(1, 0, a, 4'h0, 32'h0, 32'h0)});
        tbl.push_back('{1'b0, rq(0, 1, 5, 4'b0101, 32'hDEADBEEF, 32'h0)});
        tbl.push_back('{1'b0, rq(1, 0, 5, 4'h0, 32'h0, 32'h00AD00EF)});
        tbl.push_back('{1'b1, rq(0, 1, 7, 4'b1111, 32'hA5A51234, 32'h0)});
        tbl.push_back('{1'b0, rq(1, 0, 7, 4'h0, 32'h0, 32'hA5A51234)});
        tbl.push_back('{1'b0, rq(0, 1, 7, 4'b1000, 32'h77FFFFFF, 32'h0)});
        tbl.push_back('{1'b1, rq(1, 0, 7, 4'h0, 32'h0, 32'h77A51234)});
        tbl.push_back('{1'b1, rq(0, 1, 7, 4'b0000, 32'h0, 32'h0)});
        tbl.push_back('{1'b0, rq(1, 0, 7, 4'h0, 32'h0, 32'h77A51234)});
        tbl.push_back('{1'b0, rq(0, 1, 9, 4'b0011, 32'h1234ABCD, 32'h0)});
        tbl.push_back('{1'b1, rq(0, 1, 9, 4'b1100, 32'hBEEF0000, 32'h0)});
        tbl.push_back('{1'b1, rq(1, 0, 9, 4'h0, 32'h0, 32'hBEEFABCD)});
        tbl.push_back('{1'b0, rq(1, 0, 5, 4'h0, 32'h0, 32'h00AD00EF)});
        foreach (tbl[i]) begin
            if (tbl[i].port == 1'b0) do_cycle(tbl[i].r, nop(), 1'b1, 1'b0, 1'b0);
            else                     do_cycle(nop(), tbl[i].r, 1'b1, 1'b0, 1'b0);
        end
        drain();

        // Read and write together on one port: write only, no read return.
        do_cycle(rq(1, 1, 2, 4'hF, 32'hCAFEF00D, 32'h0), nop(), 1'b1, 1'b0, 1'b0);
        do_cycle(rq(1, 0, 2, 4'h0, 32'h0, 32'hCAFEF00D), nop(), 1'b1, 1'b0, 1'b0);
        drain();

        // Same-address write collision, then read-before-write across ports.
        do_cycle(rq(0, 1, 3, 4'hF, 32'h11111111, 32'h0),
                 rq(0, 1, 3, 4'hF, 32'h22222222, 32'h0), 1'b1, 1'b0, 1'b1);
        do_cycle(nop(), rq(0, 1, 3, 4'hF, 32'h22222222, 32'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(rq(1, 0, 3, 4'h0, 32'h0, 32'h22222222), nop(), 1'b1, 1'b0, 1'b0);
        do_cycle(rq(0, 1, 3, 4'hF, 32'h33333333, 32'h0),
                 rq(1, 0, 3, 4'h0, 32'h0, 32'h22222222), 1'b1, 1'b0, 1'b0);
        do_cycle(rq(1, 0, 3, 4'h0, 32'h0, 32'h33333333), nop(), 1'b1, 1'b0, 1'b0);
        drain();

        // Read burst with clken dropped for two cycles in the middle.
        for (int i = 0; i < 8; i++)
            do_cycle(rq(0, 1, i, 4'hF, 32'h10000000 + i * 32'h11, 32'h0), nop(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                do_cycle(rq(1, 0, i, 4'h0, 32'h0, 32'h0), nop(), 1'b0, 1'b1, 1'b1);
                do_cycle(rq(1, 0, i, 4'h0, 32'h0, 32'h0), nop(), 1'b0, 1'b1, 1'b1);
            end
            do_cycle(rq(1, 0, i, 4'h0, 32'h0, 32'h10000000 + i * 32'h11), nop(), 1'b1, 1'b0, 1'b0);
        end
        drain();

        // Out-of-range access on s2.
        chk("a_oor_before", {31'b0, oor_a}, 32'd0);
        chk("b_oor_before", {31'b0, oor_b}, 32'd0);
        do_cycle(nop(), rq(1, 0, 16, 4'h0, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(nop(), rq(0, 1, 16, 4'hF, 32'hFFFFFFFF, 32'h0), 1'b1, 1'b0, 1'b0);
        do_cycle(rq(1, 0, 0, 4'h0, 32'h0, 32'h10000000),
                 rq(1, 0, 0, 4'h0, 32'h0, 32'h10000000), 1'b1, 1'b0, 1'b0);
        drain();
        chk("a_oor_sticky", {31'b0, oor_a}, 32'd1);
        chk("b_oor_sticky", {31'b0, oor_b}, 32'd1);

        // Reset pulse clears oor_error and readdata, then reset again mid-sweep.
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        reset_n = 1'b1;
        count_sweep(n);
        chk("sweep_len_restart", n, 32'd16);

        for (int a = 0; a < 16; a++) begin
            if (a[0]) do_cycle(nop(), rq(1, 0, a, 4'h0, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
            else      do_cycle(rq(1, 0, a, 4'h0, 32'h0, 32'h0), nop(), 1'b1, 1'b0, 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
